// File: rtl/mem_req_arbiter_pkg.sv
// Shared types and widths for the memory request arbiter.
// Package name is mem_arb_pkg; the file follows the block's naming.
package mem_arb_pkg;

    localparam int MEM_ADDR_W = 4;
    localparam int MEM_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } arb_state_t;

endpackage

// File: rtl/mem_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted request strictly after 'last', wrapping.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] idx
);

    logic [IW:0] w_cand;

    // One extra bit lets last+i run past N before the wrap-around subtract.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        w_cand = '0;
        for (int i = 1; i <= N; i++) begin
            w_cand = {1'b0, last} + (IW+1)'(i);
            if (w_cand >= (IW+1)'(N)) begin
                w_cand = w_cand - (IW+1)'(N);
            end
            if (!any && req[w_cand[IW-1:0]]) begin
                any = 1'b1;
                idx = w_cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one simple-memory request port between NUM_REQ requesters,
// with a watchdog that force-completes a transaction the memory never acknowledges.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ-1:0]            req_rnw_i,
    input  logic [NUM_REQ*MEM_ADDR_W-1:0] req_addr_i,
    input  logic [NUM_REQ*MEM_DATA_W-1:0] req_wdata_i,
    output logic [NUM_REQ-1:0]            req_ready_o,
    output logic                          req_err_o,
    output logic [MEM_DATA_W-1:0]         req_rdata_o,
    output logic                          mem_req_o,
    output logic                          mem_req_rnw_o,
    output logic [MEM_ADDR_W-1:0]         mem_req_addr_o,
    output logic [MEM_DATA_W-1:0]         mem_req_wdata_o,
    input  logic                          mem_req_ready_i,
    input  logic [MEM_DATA_W-1:0]         mem_req_rdata_i
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    arb_state_t       r_state;
    logic [IDX_W-1:0] r_lastGnt;
    logic [IDX_W-1:0] r_gnt;
    logic [TMR_W-1:0] r_timer;

    logic             w_any;
    logic [IDX_W-1:0] w_pickIdx;
    logic             w_timeout;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (IDX_W)
    ) u_rrPick (
        .req  (req_i),
        .last (r_lastGnt),
        .any  (w_any),
        .idx  (w_pickIdx)
    );

    assign w_timeout = (TIMEOUT != 0) && (r_timer == TMR_W'(TIMEOUT - 1));

    // Memory ready beats the watchdog when both land in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= IDLE;
            r_lastGnt       <= IDX_W'(NUM_REQ - 1);
            r_gnt           <= '0;
            r_timer         <= '0;
            mem_req_o       <= 1'b0;
            mem_req_rnw_o   <= 1'b0;
            mem_req_addr_o  <= '0;
            mem_req_wdata_o <= '0;
            req_ready_o     <= '0;
            req_err_o       <= 1'b0;
            req_rdata_o     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_gnt           <= w_pickIdx;
                        mem_req_rnw_o   <= req_rnw_i[w_pickIdx];
                        mem_req_addr_o  <= req_addr_i[w_pickIdx*MEM_ADDR_W +: MEM_ADDR_W];
                        mem_req_wdata_o <= req_wdata_i[w_pickIdx*MEM_DATA_W +: MEM_DATA_W];
                        mem_req_o       <= 1'b1;
                        r_timer         <= '0;
                        r_state         <= BUSY;
                    end
                end
                BUSY: begin
                    if (mem_req_ready_i || w_timeout) begin
                        mem_req_o   <= 1'b0;
                        req_ready_o <= NUM_REQ'(1) << r_gnt;
                        req_err_o   <= !mem_req_ready_i;
                        if (!mem_req_ready_i) begin
                            req_rdata_o <= '0;
                        end else if (mem_req_rnw_o) begin
                            req_rdata_o <= mem_req_rdata_i;
                        end
                        r_lastGnt   <= r_gnt;
                        r_state     <= DONE;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                DONE: begin
                    req_ready_o <= '0;
                    req_err_o   <= 1'b0;
                    r_state     <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed, table-driven bench for mem_req_arbiter (NUM_REQ=2, TIMEOUT=16).
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_i;
    logic [1:0]  req_rnw_i;
    logic [7:0]  req_addr_i;
    logic [63:0] req_wdata_i;
    logic [1:0]  req_ready_o;
    logic        req_err_o;
    logic [31:0] req_rdata_o;
    logic        mem_req_o;
    logic        mem_req_rnw_o;
    logic [3:0]  mem_req_addr_o;
    logic [31:0] mem_req_wdata_o;
    logic        mem_req_ready_i;
    logic [31:0] mem_req_rdata_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  rnw;
        logic [7:0]  addr;
        logic [63:0] wdata;
        int          memCycle;
        logic [31:0] memRdata;
        logic [1:0]  expReady;
        logic [3:0]  expAddr;
        logic        expRnw;
        logic [31:0] expWdata;
        logic        expErr;
        logic [31:0] expRdata;
        int          expDone;
    } vec_t;

    vec_t vecs[7];

    mem_req_arbiter #(
        .NUM_REQ (2),
        .TIMEOUT (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_i           (req_i),
        .req_rnw_i       (req_rnw_i),
        .req_addr_i      (req_addr_i),
        .req_wdata_i     (req_wdata_i),
        .req_ready_o     (req_ready_o),
        .req_err_o       (req_err_o),
        .req_rdata_o     (req_rdata_o),
        .mem_req_o       (mem_req_o),
        .mem_req_rnw_o   (mem_req_rnw_o),
        .mem_req_addr_o  (mem_req_addr_o),
        .mem_req_wdata_o (mem_req_wdata_o),
        .mem_req_ready_i (mem_req_ready_i),
        .mem_req_rdata_i (mem_req_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Runs one transaction from IDLE: cycle 0 presents the request, memory answers in memCycle (0 = never).
    task automatic applyStimulus(input int n, input vec_t v);
        int c;
        int high;
        int doneCycle;
        c         = 0;
        high      = 0;
        doneCycle = 0;
        req_i           = v.req;
        req_rnw_i       = v.rnw;
        req_addr_i      = v.addr;
        req_wdata_i     = v.wdata;
        mem_req_ready_i = 1'b0;
        mem_req_rdata_i = 32'h0;
        while (c < 40) begin
            tick();
            c++;
            mem_req_ready_i = 1'b0;
            if (c == 1) begin
                checkOutput($sformatf("v%0d addr", n), 32'(mem_req_addr_o), 32'(v.expAddr));
                checkOutput($sformatf("v%0d rnw", n), 32'(mem_req_rnw_o), 32'(v.expRnw));
                checkOutput($sformatf("v%0d wdata", n), mem_req_wdata_o, v.expWdata);
            end
            if (req_ready_o != 2'b00) begin
                doneCycle = c;
                break;
            end
            if (mem_req_o) high++;
            if (c == v.memCycle) begin
                mem_req_ready_i = 1'b1;
                mem_req_rdata_i = v.memRdata;
            end
        end
        mem_req_ready_i = 1'b0;
        checkOutput($sformatf("v%0d doneCycle", n), 32'(doneCycle), 32'(v.expDone));
        checkOutput($sformatf("v%0d memReqCycles", n), 32'(high), 32'(v.expDone - 1));
        checkOutput($sformatf("v%0d ready", n), 32'(req_ready_o), 32'(v.expReady));
        checkOutput($sformatf("v%0d err", n), 32'(req_err_o), 32'(v.expErr));
        checkOutput($sformatf("v%0d rdata", n), req_rdata_o, v.expRdata);
        checkOutput($sformatf("v%0d memReqLow", n), 32'(mem_req_o), 32'd0);
        req_i = 2'b00;
        tick();
        checkOutput($sformatf("v%0d readyCleared", n), 32'({req_ready_o, req_err_o}), 32'd0);
    endtask

    initial begin
        //          req    rnw    addr   wdata                          mc  memRdata      expRdy addr  rnw  expWdata       err   expRdata      done
        vecs[0] = '{2'b01, 2'b01, 8'h03, 64'h0,                          2, 32'hDEADBEEF, 2'b01, 4'h3, 1'b1, 32'h0,        1'b0, 32'hDEADBEEF, 3};
        vecs[1] = '{2'b10, 2'b00, 8'hA5, 64'h12345678_0BADF00D,          1, 32'hFFFFFFFF, 2'b10, 4'hA, 1'b0, 32'h12345678, 1'b0, 32'hDEADBEEF, 2};
        vecs[2] = '{2'b11, 2'b11, 8'h72, 64'h22222222_11111111,          3, 32'h00001111, 2'b01, 4'h2, 1'b1, 32'h11111111, 1'b0, 32'h00001111, 4};
        vecs[3] = '{2'b11, 2'b01, 8'hC4, 64'hCAFEF00D_00000001,          1, 32'h55555555, 2'b10, 4'hC, 1'b0, 32'hCAFEF00D, 1'b0, 32'h00001111, 2};
        vecs[4] = '{2'b01, 2'b01, 8'h09, 64'h0,                          0, 32'h0,        2'b01, 4'h9, 1'b1, 32'h0,        1'b1, 32'h0,        17};
        vecs[5] = '{2'b01, 2'b01, 8'h01, 64'h0,                          1, 32'h13579BDF, 2'b01, 4'h1, 1'b1, 32'h0,        1'b0, 32'h13579BDF, 2};
        vecs[6] = '{2'b10, 2'b10, 8'hF0, 64'h66666666_00000000,         16, 32'hA5A5A5A5, 2'b10, 4'hF, 1'b1, 32'h66666666, 1'b0, 32'hA5A5A5A5, 17};

        reset           = 1'b1;
        req_i           = 2'b00;
        req_rnw_i       = 2'b00;
        req_addr_i      = 8'h0;
        req_wdata_i     = 64'h0;
        mem_req_ready_i = 1'b0;
        mem_req_rdata_i = 32'h0;
        repeat (3) tick();
        reset = 1'b0;
        checkOutput("reset mem fields", 32'({mem_req_o, mem_req_rnw_o, mem_req_addr_o}), 32'd0);
        checkOutput("reset wdata", mem_req_wdata_o, 32'h0);
        checkOutput("reset ready/err", 32'({req_ready_o, req_err_o}), 32'd0);
        checkOutput("reset rdata", req_rdata_o, 32'h0);

        for (int i = 0; i < 7; i++) begin
            applyStimulus(i, vecs[i]);
        end

        // Memory ready while idle must not produce any pulse or request.
        mem_req_ready_i = 1'b1;
        mem_req_rdata_i = 32'hBAD0BAD0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("idle ready ignored", 32'({req_ready_o, req_err_o, mem_req_o}), 32'd0);
        end
        checkOutput("idle rdata held", req_rdata_o, 32'hA5A5A5A5);
        mem_req_ready_i = 1'b0;

        // Continuous contention, memory answers the cycle after each request.
        req_i       = 2'b11;
        req_rnw_i   = 2'b11;
        req_addr_i  = 8'h61;
        req_wdata_i = 64'h0;
        for (int c = 1; c <= 12; c++) begin
            logic [1:0] expReady;
            tick();
            expReady = (c % 3 == 2) ? (((c / 3) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
            checkOutput($sformatf("contention ready c%0d", c), 32'(req_ready_o), 32'(expReady));
            if (c % 3 == 1) begin
                checkOutput($sformatf("contention addr c%0d", c), 32'(mem_req_addr_o),
                            ((c / 3) % 2 == 0) ? 32'h1 : 32'h6);
            end
            if (c % 3 == 2) begin
                checkOutput($sformatf("contention rdata c%0d", c), req_rdata_o, 32'h100 + 32'(c - 1));
            end
            mem_req_ready_i = mem_req_o;
            mem_req_rdata_i = 32'h100 + 32'(c);
            if (c == 11) req_i = 2'b00;
        end
        mem_req_ready_i = 1'b0;

        // Reset in the middle of a transaction.
        req_i      = 2'b10;
        req_rnw_i  = 2'b10;
        req_addr_i = 8'hB0;
        tick();
        checkOutput("pre-reset memReq", 32'(mem_req_o), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req_i = 2'b00;
        checkOutput("midreset mem fields", 32'({mem_req_o, mem_req_rnw_o, mem_req_addr_o}), 32'd0);
        checkOutput("midreset ready/err", 32'({req_ready_o, req_err_o}), 32'd0);
        checkOutput("midreset rdata", req_rdata_o, 32'h0);
        tick();
        tick();
        checkOutput("no ready after reset", 32'({req_ready_o, mem_req_o}), 32'd0);

        req_i       = 2'b11;
        req_rnw_i   = 2'b11;
        req_addr_i  = 8'h84;
        tick();
        checkOutput("post-reset grant addr", 32'(mem_req_addr_o), 32'h4);
        mem_req_ready_i = 1'b1;
        mem_req_rdata_i = 32'h00000077;
        tick();
        mem_req_ready_i = 1'b0;
        req_i = 2'b00;
        checkOutput("post-reset ready", 32'(req_ready_o), 32'(2'b01));
        checkOutput("post-reset rdata", req_rdata_o, 32'h00000077);
        tick();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
